sinegen_addr_gen: RTL and testbench
===================================

// Module: sinegen_addr_gen
// PURPOSE
//  Phase-accumulator address generator feeding the dual-port sine ROM (addr1/addr2 -> dout1/dout2).
//  Steps a fractional phase at a programmable rate and drives two ROM addresses separated by a
//  programmable phase offset. Frequency/offset updates are glitch-free: they take effect at a phase wrap.
//  Emits a valid flag aligned to the ROM's registered output, plus a per-period wrap pulse.
// PARAMETERS
//  ADDRESS_WIDTH  8                           ROM address width; must match ROM ADDRESS_WIDTH
//  ACC_WIDTH      16                          phase accumulator width; >= ADDRESS_WIDTH
//  ROM_LATENCY    1                           ROM read latency in cycles; depth of valid pipe, >= 1
//  INCR_RESET     1<<(ACC_WIDTH-ADDRESS_WIDTH) active increment after reset (1 ROM step/cycle)
// PORTS
//  clk         in   1              clock; all state updates on posedge
//  rst         in   1              synchronous reset, active-low
//  en          in   1              advance phase this cycle
//  load        in   1              latch incr_in/offset_in into shadow registers
//  incr_in     in   ACC_WIDTH      requested phase increment per cycle
//  offset_in   in   ADDRESS_WIDTH  requested addr2-addr1 phase offset
//  addr1       out  ADDRESS_WIDTH  ROM port-1 address
//  addr2       out  ADDRESS_WIDTH  ROM port-2 address
//  dout_valid  out  1              ROM dout1/dout2 valid this cycle
//  wrap        out  1              one-cycle pulse: accumulator wrapped last cycle
//  pending     out  1              shadow values loaded but not yet applied
// BEHAVIOUR
//  Reset (rst==0 at posedge): acc=0, incr_act=INCR_RESET, off_act=0, shadows=0, pending=0,
//   wrap=0, valid pipe=0, state=IDLE. Reset mid-operation discards any pending load.
//  addr1 = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH]; addr2 = addr1 + off_act mod 2^ADDRESS_WIDTH;
//   both combinational from registers, so ROM data for a given acc appears ROM_LATENCY cycles later.
//  FSM: IDLE (en==0) <-> RUN (en==1); state follows en each cycle; no other states without macro.
//  RUN: {carry,acc} <= acc + incr_act; carry = wrap event; wrap <= carry (registered pulse).
//  IDLE: acc holds; wrap <= 0.
//  Load: load==1 -> shadow <= {incr_in,offset_in}, pending <= 1. Repeated loads overwrite shadow.
//  Apply: if pending and (carry this cycle, or state==IDLE and en==0): incr_act/off_act <= shadow,
//   pending <= 0; new values govern the following cycle's step.
//  Same-cycle load and apply: apply uses the OLD shadow; the new load lands in shadow with pending=1.
//  incr_in==0 is legal: phase freezes in RUN; pending loads then apply only via IDLE.
//  dout_valid: shift register of en, depth ROM_LATENCY; dout_valid = en delayed ROM_LATENCY cycles.
// CONFIGURATION
//  Macro ADDR_GEN_SWEEP_EN. Defined: adds inputs sweep_step[ACC_WIDTH-1:0], sweep_limit[ACC_WIDTH-1:0]
//   and FSM state SWEEP (entered from RUN when sweep_step!=0): on each wrap incr_act +=
//   sweep_step, saturating at sweep_limit, then state returns to RUN. Load/apply still override incr_act;
//   an apply in the same cycle takes priority over the sweep step.
//  Undefined: ports absent, SWEEP state absent, incr_act changes only via apply.
// STRUCTURE
//  Package sinegen_pkg: addr_t, acc_t typedefs; state_t enum {IDLE,RUN,SWEEP}; default widths.
//  Sub-module sinegen_phase_acc: acc register + carry/wrap generation; top holds shadows, FSM, valid pipe.
// TESTING
//  Reset then en=1, no load: addr1 = 0,1,2,...,255,0; wrap pulses 1 cycle after 255->0; addr2==addr1.
//  load incr_in=0x0200, offset_in=0x40 at addr1=0x10 in RUN: pending=1; steps stay 1 until wrap; then
//   addr1 steps by 2, addr2=addr1+0x40 mod 256, pending=0.
//  en=0, load incr_in=0x0080: applied next cycle in IDLE; after en=1 addr1 advances every 2 cycles.
//  load on same cycle as wrap: old shadow applied, new value pending until next wrap.
//  en toggled 1,0,1,1 with ROM_LATENCY=1: dout_valid = 0,1,0,1,1 (one-cycle delayed en).
//  rst=0 mid-run with pending=1: next cycle addr1=0, pending=0, wrap=0, dout_valid=0, incr_act=INCR_RESET.

Source files
------------

// File: rtl/sinegen_pkg.sv
// Shared types and default sizes for the sine generator address path.
package sinegen_pkg;

   localparam int DEF_ADDRESS_WIDTH = 8;
   localparam int DEF_ACC_WIDTH     = 16;
   localparam int DEF_ROM_LATENCY   = 1;

   typedef logic [DEF_ADDRESS_WIDTH-1:0] addr_t;
   typedef logic [DEF_ACC_WIDTH-1:0]     acc_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      SWEEP = 2'd2
   } state_t;

endpackage

// File: rtl/sinegen_phase_acc.sv
// Phase accumulator: steps by incr when en is high, exposes the ROM address (top bits),
// the combinational carry of this cycle's step and a registered one-cycle wrap pulse.
module sinegen_phase_acc
   import sinegen_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int ACC_WIDTH     = DEF_ACC_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [ACC_WIDTH-1:0]     incr,
   output logic [ADDRESS_WIDTH-1:0] addr,
   output logic                     carry,
   output logic                     wrap
);

   logic [ACC_WIDTH-1:0] acc_r;
   logic [ACC_WIDTH:0]   sum_s;
   logic                 wrap_r;

   // Widened sum so the wrap shows up as the extra top bit.
   always_comb begin
      sum_s = {1'b0, acc_r} + {1'b0, incr};
   end

   assign carry = en & sum_s[ACC_WIDTH];
   assign addr  = acc_r[ACC_WIDTH-1 -: ADDRESS_WIDTH];
   assign wrap  = wrap_r;

   // Accumulator holds while idle; wrap is the carry delayed by one cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_r  <= {ACC_WIDTH{1'b0}};
         wrap_r <= 1'b0;
      end else if (en) begin
         acc_r  <= sum_s[ACC_WIDTH-1:0];
         wrap_r <= sum_s[ACC_WIDTH];
      end else begin
         wrap_r <= 1'b0;
      end
   end

endmodule

// File: rtl/sinegen_addr_gen.sv
// Dual-address generator for the sine ROM with glitch-free (wrap-aligned) rate/offset updates.
// Optional macro ADDR_GEN_SWEEP_EN adds sweep_step/sweep_limit and a per-wrap increment sweep.
module sinegen_addr_gen
   import sinegen_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
   parameter int ROM_LATENCY   = DEF_ROM_LATENCY,
   parameter logic [ACC_WIDTH-1:0] INCR_RESET =
      {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (ACC_WIDTH - ADDRESS_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     load,
   input  logic [ACC_WIDTH-1:0]     incr_in,
   input  logic [ADDRESS_WIDTH-1:0] offset_in,
   output logic [ADDRESS_WIDTH-1:0] addr1,
   output logic [ADDRESS_WIDTH-1:0] addr2,
   output logic                     dout_valid,
   output logic                     wrap,
   output logic                     pending
`ifdef ADDR_GEN_SWEEP_EN
   ,
   input  logic [ACC_WIDTH-1:0]     sweep_step,
   input  logic [ACC_WIDTH-1:0]     sweep_limit
`endif
);

   state_t                   state_r;
   state_t                   state_nxt_s;
   logic [ACC_WIDTH-1:0]     incr_act_r;
   logic [ACC_WIDTH-1:0]     incr_nxt_s;
   logic [ADDRESS_WIDTH-1:0] off_act_r;
   logic [ADDRESS_WIDTH-1:0] off_nxt_s;
   logic [ACC_WIDTH-1:0]     shadow_incr_r;
   logic [ADDRESS_WIDTH-1:0] shadow_off_r;
   logic                     pending_r;
   logic                     apply_s;
   logic                     carry_s;
   logic                     wrap_s;
   logic [ADDRESS_WIDTH-1:0] addr_s;
   logic [ROM_LATENCY-1:0]   valid_pipe_r;

   sinegen_phase_acc #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH)
   ) u_phase_acc (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .incr  (incr_act_r),
      .addr  (addr_s),
      .carry (carry_s),
      .wrap  (wrap_s)
   );

   // Shadow values take effect only at a wrap, or while the generator is parked.
   assign apply_s = pending_r & (carry_s | ((state_r == IDLE) & ~en));

`ifdef ADDR_GEN_SWEEP_EN
   logic [ACC_WIDTH:0]   sweep_sum_s;
   logic [ACC_WIDTH-1:0] sweep_sat_s;

   // Saturating sweep increment, clamped at sweep_limit.
   always_comb begin
      sweep_sum_s = {1'b0, incr_act_r} + {1'b0, sweep_step};
      if (sweep_sum_s > {1'b0, sweep_limit}) begin
         sweep_sat_s = sweep_limit;
      end else begin
         sweep_sat_s = sweep_sum_s[ACC_WIDTH-1:0];
      end
   end
`endif

   // State follows en; with sweep enabled RUN hands over to SWEEP until the next wrap.
   always_comb begin
      state_nxt_s = state_r;
      if (!en) begin
         state_nxt_s = IDLE;
      end else begin
`ifdef ADDR_GEN_SWEEP_EN
         case (state_r)
            IDLE:    state_nxt_s = RUN;
            RUN:     state_nxt_s = (sweep_step != {ACC_WIDTH{1'b0}}) ? SWEEP : RUN;
            SWEEP:   state_nxt_s = carry_s ? RUN : SWEEP;
            default: state_nxt_s = RUN;
         endcase
`else
         state_nxt_s = RUN;
`endif
      end
   end

   // Apply beats the sweep step when both land in the same cycle.
   always_comb begin
      incr_nxt_s = incr_act_r;
      off_nxt_s  = off_act_r;
      if (apply_s) begin
         incr_nxt_s = shadow_incr_r;
         off_nxt_s  = shadow_off_r;
      end
`ifdef ADDR_GEN_SWEEP_EN
      else if ((state_r == SWEEP) && carry_s) begin
         incr_nxt_s = sweep_sat_s;
         off_nxt_s  = off_act_r;
      end
`endif
      else begin
         incr_nxt_s = incr_act_r;
         off_nxt_s  = off_act_r;
      end
   end

   // Control registers; a same-cycle load refills the shadow after apply consumed the old one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= IDLE;
         incr_act_r    <= INCR_RESET;
         off_act_r     <= {ADDRESS_WIDTH{1'b0}};
         shadow_incr_r <= {ACC_WIDTH{1'b0}};
         shadow_off_r  <= {ADDRESS_WIDTH{1'b0}};
         pending_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         incr_act_r <= incr_nxt_s;
         off_act_r  <= off_nxt_s;
         if (load) begin
            shadow_incr_r <= incr_in;
            shadow_off_r  <= offset_in;
            pending_r     <= 1'b1;
         end else if (apply_s) begin
            pending_r <= 1'b0;
         end
      end
   end

   // en delayed by the ROM read latency.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_pipe_r <= {ROM_LATENCY{1'b0}};
      end else begin
         valid_pipe_r[0] <= en;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            valid_pipe_r[i] <= valid_pipe_r[i-1];
         end
      end
   end

   assign addr1      = addr_s;
   assign addr2      = addr_s + off_act_r;
   assign wrap       = wrap_s;
   assign pending    = pending_r;
   assign dout_valid = valid_pipe_r[ROM_LATENCY-1];

endmodule

// File: tb/tb_sinegen_addr_gen.sv
// Self-checking bench for sinegen_addr_gen (default build, 8-bit address, 16-bit phase).
module tb_sinegen_addr_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] incr_in = 16'h0000;
   logic [7:0]  offset_in = 8'h00;
   logic [7:0]  addr1;
   logic [7:0]  addr2;
   logic        dout_valid;
   logic        wrap;
   logic        pending;

   int errors = 0;
   int checks = 0;

   // Reference: phase as an integer 0..65535, rate/offset, shadow and pending flag.
   int unsigned m_acc, m_incr, m_off, m_sh_incr, m_sh_off;
   bit          m_pend, m_parked, m_wrap, m_valid;

   always #5 clk = ~clk;

   sinegen_addr_gen dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .incr_in    (incr_in),
      .offset_in  (offset_in),
      .addr1      (addr1),
      .addr2      (addr2),
      .dout_valid (dout_valid),
      .wrap       (wrap),
      .pending    (pending)
   );

   function automatic logic [7:0] exp_a1();
      return 8'(m_acc / 256);
   endfunction

   function automatic logic [7:0] exp_a2();
      return 8'((m_acc / 256 + m_off) % 256);
   endfunction

   // One clock with the given inputs; the model advances by the stated rules.
   task automatic cycle(input bit e, input bit l, input int unsigned ii, input int unsigned oo);
      int unsigned sum;
      bit carry, apply;
      rst = 1'b1; en = e; load = l; incr_in = 16'(ii); offset_in = 8'(oo);
      sum   = m_acc + (e ? m_incr : 0);
      carry = e && (sum >= 65536);
      apply = m_pend && (carry || (m_parked && !e));
      if (e) m_acc = sum % 65536;
      m_wrap = carry;
      if (apply) begin
         m_incr = m_sh_incr;
         m_off  = m_sh_off;
      end
      if (l) begin
         m_sh_incr = ii % 65536;
         m_sh_off  = oo % 256;
         m_pend    = 1'b1;
      end else if (apply) begin
         m_pend = 1'b0;
      end
      m_parked = !e;
      m_valid  = e;
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input bit e);
      rst = 1'b0; en = e; load = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      m_acc = 0; m_incr = 256; m_off = 0; m_sh_incr = 0; m_sh_off = 0;
      m_pend = 1'b0; m_parked = 1'b1; m_wrap = 1'b0; m_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      checks += 4;
      if (addr1 !== 8'h00) begin errors++; $display("FAIL reset_addr1: got %0h expected 0", addr1); end
      if (addr2 !== 8'h00) begin errors++; $display("FAIL reset_addr2: got %0h expected 0", addr2); end
      if ({wrap, pending, dout_valid} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: wrap/pending/valid got %b expected 000", {wrap, pending, dout_valid});
      end
      cycle(1'b0, 1'b0, 0, 0);
      if (addr1 !== 8'h00) begin errors++; $display("FAIL reset_hold: got %0h expected 0", addr1); end
   endtask

   task automatic test_free_run();
      for (int k = 1; k <= 257; k++) begin
         cycle(1'b1, 1'b0, 0, 0);
         checks += 4;
         if (addr1 !== 8'(k % 256)) begin errors++; $display("FAIL run_addr1 k=%0d: got %0h expected %0h", k, addr1, k % 256); end
         if (addr2 !== 8'(k % 256)) begin errors++; $display("FAIL run_addr2 k=%0d: got %0h expected %0h", k, addr2, k % 256); end
         if (wrap !== (k == 256)) begin errors++; $display("FAIL run_wrap k=%0d: got %b expected %b", k, wrap, k == 256); end
         if (dout_valid !== 1'b1) begin errors++; $display("FAIL run_valid k=%0d: got %b expected 1", k, dout_valid); end
      end
   endtask

   task automatic test_load_run();
      int n;
      for (int k = 0; k < 15; k++) cycle(1'b1, 1'b0, 0, 0);
      checks++;
      if (addr1 !== 8'h10) begin errors++; $display("FAIL load_pos: got %0h expected 10", addr1); end
      cycle(1'b1, 1'b1, 32'h0200, 32'h40);
      checks += 2;
      if (pending !== 1'b1) begin errors++; $display("FAIL load_pending: got %b expected 1", pending); end
      if (addr1 !== 8'h11) begin errors++; $display("FAIL load_still_step1: got %0h expected 11", addr1); end
      n = 0;
      while (!m_wrap && n < 300) begin
         cycle(1'b1, 1'b0, 0, 0);
         n++;
         checks += 2;
         if (addr1 !== exp_a1()) begin errors++; $display("FAIL load_walk_addr1: got %0h expected %0h", addr1, exp_a1()); end
         if (pending !== m_pend) begin errors++; $display("FAIL load_walk_pending: got %b expected %b", pending, m_pend); end
      end
      checks += 4;
      if (n != 239) begin errors++; $display("FAIL load_wrap_cycles: got %0d expected 239", n); end
      if (addr1 !== 8'h00 || addr2 !== 8'h40) begin
         errors++; $display("FAIL load_at_wrap: addr1/addr2 got %0h/%0h expected 0/40", addr1, addr2);
      end
      if ({wrap, pending} !== 2'b10) begin errors++; $display("FAIL load_applied: wrap/pending got %b expected 10", {wrap, pending}); end
      cycle(1'b1, 1'b0, 0, 0);
      if (addr1 !== 8'h02 || addr2 !== 8'h42) begin
         errors++; $display("FAIL load_step2: addr1/addr2 got %0h/%0h expected 2/42", addr1, addr2);
      end
   endtask

   task automatic test_idle_load();
      int unsigned base;
      cycle(1'b0, 1'b1, 32'h0080, 32'h00);
      checks += 2;
      if (pending !== 1'b1) begin errors++; $display("FAIL idle_load_pending: got %b expected 1", pending); end
      cycle(1'b0, 1'b0, 0, 0);
      if (pending !== 1'b0) begin errors++; $display("FAIL idle_apply: got pending %b expected 0", pending); end
      base = m_acc;
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b1, 1'b0, 0, 0);
         checks += 2;
         if (addr1 !== 8'(((base + k * 32'h80) % 65536) / 256)) begin
            errors++; $display("FAIL idle_half_rate k=%0d: got %0h expected %0h", k, addr1, ((base + k * 32'h80) % 65536) / 256);
         end
         if (addr2 !== addr1) begin errors++; $display("FAIL idle_offset0 k=%0d: got %0h expected %0h", k, addr2, addr1); end
      end
   endtask

   task automatic test_load_at_wrap();
      int n;
      cycle(1'b1, 1'b1, 32'h0100, 32'h10);
      n = 0;
      while (m_acc + m_incr < 65536 && n < 1200) begin
         cycle(1'b1, 1'b0, 0, 0);
         n++;
      end
      checks += 4;
      if (n >= 1200) begin errors++; $display("FAIL lw_reach_wrap: got %0d cycles expected < 1200", n); end
      cycle(1'b1, 1'b1, 32'h0400, 32'h20);
      if ({wrap, pending} !== 2'b11) begin errors++; $display("FAIL lw_wrap_pending: got %b expected 11", {wrap, pending}); end
      if (8'(addr2 - addr1) !== 8'h10) begin errors++; $display("FAIL lw_old_offset: got %0h expected 10", 8'(addr2 - addr1)); end
      cycle(1'b1, 1'b0, 0, 0);
      if (addr1 !== exp_a1() || m_incr != 32'h100) begin
         errors++; $display("FAIL lw_old_rate: got %0h expected %0h", addr1, exp_a1());
      end
      n = 0;
      while (!m_wrap && n < 300) begin
         cycle(1'b1, 1'b0, 0, 0);
         n++;
      end
      checks += 3;
      if (pending !== 1'b0 || wrap !== 1'b1) begin errors++; $display("FAIL lw_second_apply: wrap/pending got %b%b expected 10", wrap, pending); end
      if (8'(addr2 - addr1) !== 8'h20) begin errors++; $display("FAIL lw_new_offset: got %0h expected 20", 8'(addr2 - addr1)); end
      cycle(1'b1, 1'b0, 0, 0);
      if (addr1 !== exp_a1()) begin errors++; $display("FAIL lw_new_rate: got %0h expected %0h", addr1, exp_a1()); end
   endtask

   task automatic test_valid_toggle();
      bit seq [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 5; k++) begin
         cycle(seq[k], 1'b0, 0, 0);
         checks++;
         if (dout_valid !== seq[k]) begin errors++; $display("FAIL valid_seq k=%0d: got %b expected %b", k, dout_valid, seq[k]); end
      end
   endtask

   task automatic test_reset_mid_run();
      cycle(1'b1, 1'b1, 32'h0300, 32'h11);
      checks += 4;
      if (pending !== 1'b1) begin errors++; $display("FAIL rst_pre_pending: got %b expected 1", pending); end
      do_reset(1'b1);
      if (addr1 !== 8'h00 || addr2 !== 8'h00) begin
         errors++; $display("FAIL rst_mid_addr: got %0h/%0h expected 0/0", addr1, addr2);
      end
      if ({wrap, pending, dout_valid} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_flags: got %b expected 000", {wrap, pending, dout_valid});
      end
      cycle(1'b1, 1'b0, 0, 0);
      if (addr1 !== 8'h01 || addr2 !== 8'h01 || dout_valid !== 1'b1 || pending !== 1'b0) begin
         errors++; $display("FAIL rst_mid_after: addr1=%0h addr2=%0h valid=%b pending=%b expected 1 1 1 0", addr1, addr2, dout_valid, pending);
      end
   endtask

   task automatic test_random();
      int unsigned ii, sel;
      bit e, l;
      for (int k = 0; k < 3000; k++) begin
         e   = ($urandom_range(0, 9) < 8);
         l   = ($urandom_range(0, 15) == 0);
         sel = $urandom_range(0, 9);
         if (sel == 0)      ii = 0;
         else if (sel < 5)  ii = $urandom_range(1, 32'h0800);
         else if (sel < 9)  ii = $urandom_range(32'h0100, 32'h2000);
         else               ii = $urandom_range(0, 32'hFFFF);
         cycle(e, l, ii, $urandom_range(0, 255));
         checks += 5;
         if (addr1 !== exp_a1()) begin errors++; $display("FAIL rand_addr1 k=%0d: got %0h expected %0h", k, addr1, exp_a1()); end
         if (addr2 !== exp_a2()) begin errors++; $display("FAIL rand_addr2 k=%0d: got %0h expected %0h", k, addr2, exp_a2()); end
         if (wrap !== m_wrap) begin errors++; $display("FAIL rand_wrap k=%0d: got %b expected %b", k, wrap, m_wrap); end
         if (pending !== m_pend) begin errors++; $display("FAIL rand_pending k=%0d: got %b expected %b", k, pending, m_pend); end
         if (dout_valid !== m_valid) begin errors++; $display("FAIL rand_valid k=%0d: got %b expected %b", k, dout_valid, m_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_load_run();
      test_idle_load();
      test_load_at_wrap();
      test_valid_toggle();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
